// File: rtl/controle_pkg.sv
// controle_pkg: shared states, opcodes and ALU codes for the multicycle controller
package controle_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, CLEAR, WB, HALT} state_t;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b101;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_ST  = 3'b111;
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0001;
  function automatic logic [3:0] alu_code(input logic [2:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_MUL ? ALU_MUL : ALU_DIV;
  endfunction
endpackage

// File: rtl/contador_espera.sv
// contador_espera: handshake wait counter with timeout flag
//   clr: restart count, en: this is a wait cycle, expired: this wait cycle is the WAIT_MAX-th
module contador_espera #(
  parameter int WAIT_MAX = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt;
  // flagged during the last allowed wait cycle so the caller leaves on the same edge the count reaches WAIT_MAX
  assign expired = en && cnt == CW'(WAIT_MAX - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for ALU, memory access, memory clear and halt
//   instr_valid/opcode/instr_ready: opcode handshake; alu_start/alu_done: ALU launch and completion
//   mem_ready: memory access done; resume: leave HALT; MemtoReg..Clear, ALUCode: datapath controls
//   clr_addr: address being cleared; err: sticky fault (bad opcode or timeout)
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int OPW       = 3,
  parameter int MEM_DEPTH = 16,
  parameter int WAIT_MAX  = 64,
  localparam int ADDR_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [OPW-1:0]    opcode,
  output logic              instr_ready,
  input  logic              alu_done,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              alu_start,
  output logic              MemtoReg,
  output logic              MemEn,
  output logic              MemOp,
  output logic              FonteEscrita,
  output logic              RegEsc,
  output logic              Stop,
  output logic              Clear,
  output logic [3:0]        ALUCode,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              err
);
  state_t state, nxt;
  logic [OPW-1:0] op;
  logic [2:0] lo;
  logic bad, last, cnt_clr, cnt_en, expired, err_set;
  assign lo = op[2:0];
  assign bad = (op >> 3) != '0;
  assign last = clr_addr == ADDR_W'(MEM_DEPTH - 1);
  contador_espera #(.WAIT_MAX(WAIT_MAX)) u_espera (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_en), .expired(expired)
  );
  always_comb begin
    nxt = state;
    instr_ready = 1'b0;
    alu_start = 1'b0;
    MemtoReg = 1'b0;
    MemEn = 1'b0;
    MemOp = 1'b0;
    FonteEscrita = 1'b0;
    RegEsc = 1'b0;
    Stop = 1'b0;
    Clear = 1'b0;
    ALUCode = ALU_DIV;
    cnt_clr = 1'b0;
    cnt_en = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) nxt = DECODE;
      end
      DECODE: begin
        cnt_clr = 1'b1;
        if (bad) begin
          nxt = HALT;
          err_set = 1'b1;
        end else if (!lo[2]) begin
          alu_start = 1'b1;
          nxt = EXEC;
        end else nxt = lo == OP_CLR ? CLEAR : lo == OP_HLT ? HALT : MEM;
      end
      EXEC: begin
        ALUCode = alu_code(lo);
        cnt_en = !alu_done;
        if (alu_done) nxt = WB;
        else if (expired) begin
          nxt = HALT;
          err_set = 1'b1;
        end
      end
      MEM: begin
        MemEn = 1'b1;
        MemOp = lo[0];
        cnt_en = !mem_ready;
        if (mem_ready) nxt = lo[0] ? IDLE : WB;
        else if (expired) begin
          nxt = HALT;
          err_set = 1'b1;
        end
      end
      CLEAR: begin
        MemEn = 1'b1;
        Clear = 1'b1;
        cnt_en = !mem_ready;
        cnt_clr = mem_ready;
        if (mem_ready && last) nxt = IDLE;
        else if (expired) begin
          nxt = HALT;
          err_set = 1'b1;
        end
      end
      WB: begin
        RegEsc = 1'b1;
        MemtoReg = lo == OP_LD;
        FonteEscrita = lo == OP_LD;
        ALUCode = lo[2] ? ALU_DIV : alu_code(lo);
        nxt = IDLE;
      end
      HALT: begin
        Stop = 1'b1;
        if (resume) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      clr_addr <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && instr_valid) op <= opcode;
      err <= err | err_set;
      // address only advances while the sweep continues; leaving CLEAR (done or timeout) parks it at 0
      clr_addr <= nxt != CLEAR ? '0 : (state == CLEAR && mem_ready) ? clr_addr + ADDR_W'(1) : clr_addr;
    end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized self-checking bench against a transaction-level model
module tb_controle_multiciclo;
  localparam int OPW = 4;
  localparam int MD  = 4;
  localparam int WM  = 8;
  localparam int N   = 128;
  logic clk = 1'b0;
  logic rst_n, instr_valid, instr_ready, alu_done, mem_ready, resume, alu_start;
  logic MemtoReg, MemEn, MemOp, FonteEscrita, RegEsc, Stop, Clear, err;
  logic [OPW-1:0] opcode;
  logic [3:0] ALUCode;
  logic [1:0] clr_addr;
  logic [15:0] obs;
  int checks = 0;
  int passed = 0;
  bit err_m;
  bit iv_a[N], rs_a[N], ad_a[N], mr_a[N];
  logic [15:0] exp_q[$];
  int acc_idx;
  logic [OPW-1:0] cur_op;
  always #5 clk = ~clk;
  controle_multiciclo #(.OPW(OPW), .MEM_DEPTH(MD), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .instr_ready(instr_ready),
    .alu_done(alu_done), .mem_ready(mem_ready), .resume(resume), .alu_start(alu_start),
    .MemtoReg(MemtoReg), .MemEn(MemEn), .MemOp(MemOp), .FonteEscrita(FonteEscrita), .RegEsc(RegEsc),
    .Stop(Stop), .Clear(Clear), .ALUCode(ALUCode), .clr_addr(clr_addr), .err(err)
  );
  assign obs = {instr_ready, alu_start, MemtoReg, MemEn, MemOp, FonteEscrita, RegEsc, Stop, Clear, ALUCode, clr_addr, err};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [15:0] v(bit ir, bit as, bit m2r, bit men, bit mop, bit fe, bit re, bit stp,
                                    bit clr, logic [3:0] code, logic [1:0] ca, bit e);
    return {ir, as, m2r, men, mop, fe, re, stp, clr, code, ca, e};
  endfunction
  function automatic logic [15:0] idle_v();
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2'd0, err_m);
  endfunction
  function automatic logic [15:0] halt_v();
    return v(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 2'd0, err_m);
  endfunction
  function automatic logic [3:0] code_of(input logic [2:0] lo);
    case (lo)
      3'd0: return 4'b1000;
      3'd1: return 4'b0100;
      3'd2: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction
  function automatic void noise(input int p, input bit quiet);
    for (int i = 0; i < N; i++) begin
      ad_a[i] = !quiet && ($urandom_range(0, 7) < p);
      mr_a[i] = !quiet && ($urandom_range(0, 7) < p);
      iv_a[i] = !quiet && ($urandom_range(0, 1) == 1);
      rs_a[i] = !quiet && ($urandom_range(0, 1) == 1);
    end
  endfunction
  function automatic void build(input logic [OPW-1:0] op, input int gap, input int hn);
    int c, a, n;
    bit done, halt;
    logic [2:0] lo;
    exp_q.delete();
    c = 0;
    lo = op[2:0];
    halt = 0;
    done = 0;
    for (int i = 0; i < gap; i++) begin
      iv_a[c] = 0;
      exp_q.push_back(idle_v());
      c++;
    end
    acc_idx = c;
    iv_a[c] = 1;
    exp_q.push_back(idle_v());
    c++;
    exp_q.push_back(v(0, !op[3] && !lo[2], 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2'd0, err_m));
    c++;
    if (op[3]) begin
      halt = 1;
      err_m = 1;
    end else if (!lo[2]) begin
      for (int i = 0; i < WM && !done; i++) begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, code_of(lo), 2'd0, err_m));
        done = ad_a[c];
        c++;
      end
      if (done) begin
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, code_of(lo), 2'd0, err_m));
        c++;
      end else begin
        halt = 1;
        err_m = 1;
      end
    end else if (lo[1]) begin
      for (int i = 0; i < WM && !done; i++) begin
        exp_q.push_back(v(0, 0, 0, 1, lo[0], 0, 0, 0, 0, 4'b0001, 2'd0, err_m));
        done = mr_a[c];
        c++;
      end
      if (!done) begin
        halt = 1;
        err_m = 1;
      end else if (!lo[0]) begin
        exp_q.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0, 4'b0001, 2'd0, err_m));
        c++;
      end
    end else if (!lo[0]) begin
      a = 0;
      n = 0;
      while (!done && !halt) begin
        exp_q.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 4'b0001, 2'(a), err_m));
        if (mr_a[c]) begin
          if (a == MD - 1) done = 1;
          else begin
            a++;
            n = 0;
          end
        end else begin
          n++;
          if (n == WM) begin
            halt = 1;
            err_m = 1;
          end
        end
        c++;
      end
    end else halt = 1;
    if (halt) begin
      for (int i = 0; i < hn; i++) begin
        rs_a[c] = 0;
        exp_q.push_back(halt_v());
        c++;
      end
      rs_a[c] = 1;
      iv_a[c] = 1;
      exp_q.push_back(halt_v());
      c++;
      iv_a[c] = 0;
      exp_q.push_back(idle_v());
      c++;
    end
  endfunction
  task automatic drive(input int i);
    instr_valid = iv_a[i];
    resume = rs_a[i];
    alu_done = ad_a[i];
    mem_ready = mr_a[i];
    opcode = (i == acc_idx) ? cur_op : OPW'($urandom_range(0, 15));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(i);
      @(negedge clk);
      check($sformatf("op%0h cyc%0d", cur_op, i), obs, exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic [OPW-1:0] op, input int gap, input int hn);
    cur_op = op;
    build(op, gap, hn);
    run(exp_q.size());
  endtask
  initial begin
    logic [15:0] t;
    int k;
    logic [OPW-1:0] op;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    opcode = '0;
    alu_done = 1'b0;
    mem_ready = 1'b0;
    resume = 1'b0;
    #1 rst_n = 1'b0;
    err_m = 0;
    repeat (2) @(negedge clk);
    check("reset", obs, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    noise(0, 1);
    go(4'h5, 0, 1);
    noise(0, 1);
    ad_a[4] = 1;
    go(4'h0, 0, 1);
    noise(0, 1);
    mr_a[3] = 1;
    go(4'h6, 0, 1);
    noise(0, 1);
    for (int i = 0; i < N; i++) mr_a[i] = i[0];
    go(4'h4, 0, 1);
    noise(0, 1);
    go(4'h7, 0, 2);
    noise(0, 1);
    go(4'h8, 1, 1);
    for (int r = 0; r < 60; r++) begin
      op = OPW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op[3] = 1'b0;
      noise($urandom_range(0, 4), 0);
      go(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    noise(0, 1);
    for (int i = 0; i < N; i++) mr_a[i] = i[0];
    cur_op = 4'h4;
    build(4'h4, 0, 1);
    k = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      t = exp_q[i];
      if (k == 0 && t[7] && t[2:1] == 2'd2) k = i;
    end
    run(k);
    drive(k);
    #1 check("pre-reset clear", obs, exp_q[k]);
    rst_n = 1'b0;
    #1 check("async reset", obs, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 0));
    err_m = 0;
    @(negedge clk);
    check("reset hold", obs, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 2'd0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    noise(0, 1);
    ad_a[3] = 1;
    go(4'h1, 0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
